// File: rtl/dac_wave_gen.sv
// DDS waveform source for an 8-bit DAC: saw/triangle/square/DC with amplitude
// scale, offset with saturation, and a period marker aligned to the first sample.
module dac_wave_gen #(
  parameter int unsigned PHASE_W = 24
) (
  input  logic               da_clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fword,
  input  logic [1:0]         cfg_wave,
  input  logic [7:0]         cfg_amp,
  input  logic [7:0]         cfg_offs,
  output logic [7:0]         da_data,
  output logic               da_pulse,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               first_q, first_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;

  logic [PHASE_W-1:0] fword_q, fword_d;
  logic [1:0]         wave_q, wave_d;
  logic [7:0]         amp_q, amp_d;
  logic [7:0]         offs_q, offs_d;

  logic               pend_full_q, pend_full_d;
  logic [PHASE_W-1:0] pend_fword_q, pend_fword_d;
  logic [1:0]         pend_wave_q, pend_wave_d;
  logic [7:0]         pend_amp_q, pend_amp_d;
  logic [7:0]         pend_offs_q, pend_offs_d;

  logic [7:0]         s_q, s_d;
  logic [7:0]         amp1_q, amp1_d;
  logic [7:0]         offs1_q, offs1_d;
  logic               pulse1_q, pulse1_d;
  logic [7:0]         prod_hi_q, prod_hi_d;
  logic [7:0]         offs2_q, offs2_d;
  logic               pulse2_q, pulse2_d;
  logic [7:0]         data_q, data_d;
  logic               pulse3_q, pulse3_d;

  logic [PHASE_W:0]   sum;
  logic               wrap;
  logic               copy;
  logic               accept;
  logic [7:0]         p;
  logic [8:0]         y;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, fword_q};
    state_d = state_q;
    acc_d   = acc_q;
    wrap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        acc_d = sum[PHASE_W-1:0];
        wrap  = sum[PHASE_W];
        if (!enable) state_d = STOP;
      end
      STOP: begin
        acc_d = sum[PHASE_W-1:0];
        wrap  = sum[PHASE_W];
        if (enable) begin
          state_d = RUN;
        end else if (sum[PHASE_W] || (fword_q == '0)) begin
          state_d = IDLE;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
    first_d = (state_q == IDLE) && enable;
    wrap_d  = wrap;
    busy_d  = (state_d != IDLE);

    // Pending config lands on the wrap so the next sample (the marked one) uses it.
    copy   = pend_full_q && ((state_q == IDLE) || wrap);
    accept = cfg_valid && !pend_full_q;

    fword_d      = copy ? pend_fword_q : fword_q;
    wave_d       = copy ? pend_wave_q  : wave_q;
    amp_d        = copy ? pend_amp_q   : amp_q;
    offs_d       = copy ? pend_offs_q  : offs_q;
    pend_fword_d = accept ? cfg_fword : pend_fword_q;
    pend_wave_d  = accept ? cfg_wave  : pend_wave_q;
    pend_amp_d   = accept ? cfg_amp   : pend_amp_q;
    pend_offs_d  = accept ? cfg_offs  : pend_offs_q;
    pend_full_d  = accept ? 1'b1 : (copy ? 1'b0 : pend_full_q);

    p = acc_q[PHASE_W-1 -: 8];
    unique case (wave_q)
      2'd0:    s_d = p;
      2'd1:    s_d = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      2'd2:    s_d = p[7] ? 8'h00 : 8'hFF;
      default: s_d = 8'hFF;
    endcase
    if (state_q == IDLE) s_d = '0;
    amp1_d   = amp_q;
    offs1_d  = offs_q;
    pulse1_d = (state_q != IDLE) && (first_q || wrap_q);

    prod_hi_d = 8'(({8'h00, s_q} * {8'h00, amp1_q}) >> 8);
    offs2_d   = offs1_q;
    pulse2_d  = pulse1_q;

    y        = {1'b0, offs2_q} + {1'b0, prod_hi_q};
    data_d   = y[8] ? 8'hFF : y[7:0];
    pulse3_d = pulse2_q;
  end

  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      first_q      <= 1'b0;
      wrap_q       <= 1'b0;
      busy_q       <= 1'b0;
      fword_q      <= '0;
      wave_q       <= '0;
      amp_q        <= '0;
      offs_q       <= '0;
      pend_full_q  <= 1'b0;
      pend_fword_q <= '0;
      pend_wave_q  <= '0;
      pend_amp_q   <= '0;
      pend_offs_q  <= '0;
      s_q          <= '0;
      amp1_q       <= '0;
      offs1_q      <= '0;
      pulse1_q     <= 1'b0;
      prod_hi_q    <= '0;
      offs2_q      <= '0;
      pulse2_q     <= 1'b0;
      data_q       <= '0;
      pulse3_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      first_q      <= first_d;
      wrap_q       <= wrap_d;
      busy_q       <= busy_d;
      fword_q      <= fword_d;
      wave_q       <= wave_d;
      amp_q        <= amp_d;
      offs_q       <= offs_d;
      pend_full_q  <= pend_full_d;
      pend_fword_q <= pend_fword_d;
      pend_wave_q  <= pend_wave_d;
      pend_amp_q   <= pend_amp_d;
      pend_offs_q  <= pend_offs_d;
      s_q          <= s_d;
      amp1_q       <= amp1_d;
      offs1_q      <= offs1_d;
      pulse1_q     <= pulse1_d;
      prod_hi_q    <= prod_hi_d;
      offs2_q      <= offs2_d;
      pulse2_q     <= pulse2_d;
      data_q       <= data_d;
      pulse3_q     <= pulse3_d;
    end
  end

  assign cfg_ready = !pend_full_q;
  assign da_data   = data_q;
  assign da_pulse  = pulse3_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Bench for dac_wave_gen: arithmetic reference model compared every cycle,
// directed scenarios with hand-computed values, then randomized traffic.
module tb_dac_wave_gen;
  localparam int unsigned W = 24;
  localparam longint unsigned MOD = 64'd1 << W;

  logic         da_clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_fword;
  logic [1:0]   cfg_wave;
  logic [7:0]   cfg_amp;
  logic [7:0]   cfg_offs;
  logic [7:0]   da_data;
  logic         da_pulse;
  logic         busy;

  dac_wave_gen #(.PHASE_W(W)) dut (
    .da_clk(da_clk), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fword(cfg_fword), .cfg_wave(cfg_wave), .cfg_amp(cfg_amp), .cfg_offs(cfg_offs),
    .da_data(da_data), .da_pulse(da_pulse), .busy(busy)
  );

  always #5 da_clk = ~da_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint unsigned m_phase;
  longint unsigned m_fword, m_pfword;
  int  m_wave, m_amp, m_offs, m_pwave, m_pamp, m_poffs;
  bit  m_busy, m_stopping, m_new_period, m_pend_full;
  int  pd[3];
  bit  pp[3];

  function automatic int shape(input int wave, input int p);
    case (wave)
      0:       return p;
      1:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      2:       return (p < 128) ? 255 : 0;
      default: return 255;
    endcase
  endfunction

  always @(posedge da_clk or posedge rst) begin
    int s, y;
    longint unsigned nxt;
    bit wrapped, copy, accept;
    if (rst) begin
      m_phase = 0; m_fword = 0; m_wave = 0; m_amp = 0; m_offs = 0;
      m_pfword = 0; m_pwave = 0; m_pamp = 0; m_poffs = 0;
      m_busy = 0; m_stopping = 0; m_new_period = 0; m_pend_full = 0;
      for (int i = 0; i < 3; i++) begin pd[i] = 0; pp[i] = 0; end
    end else begin
      s = m_busy ? shape(m_wave, int'(m_phase >> (W - 8))) : 0;
      y = m_offs + (s * m_amp) / 256;
      if (y > 255) y = 255;
      pd[2] = pd[1]; pd[1] = pd[0]; pd[0] = y;
      pp[2] = pp[1]; pp[1] = pp[0]; pp[0] = m_busy && m_new_period;

      nxt     = m_phase + m_fword;
      wrapped = m_busy && (nxt >= MOD);
      copy    = m_pend_full && (!m_busy || wrapped);
      accept  = cfg_valid && !m_pend_full;

      if (!m_busy) begin
        m_phase = 0;
        m_busy = enable;
        m_new_period = enable;
        m_stopping = 0;
      end else begin
        m_phase = nxt % MOD;
        m_new_period = wrapped;
        if (enable) m_stopping = 0;
        else if (m_stopping && (wrapped || m_fword == 0)) begin
          m_busy = 0; m_phase = 0; m_stopping = 0;
        end else m_stopping = 1;
      end

      if (copy) begin
        m_fword = m_pfword; m_wave = m_pwave; m_amp = m_pamp; m_offs = m_poffs;
        m_pend_full = 0;
      end
      if (accept) begin
        m_pfword = cfg_fword; m_pwave = cfg_wave; m_pamp = cfg_amp; m_poffs = cfg_offs;
        m_pend_full = 1;
      end
    end
  end

  always @(negedge da_clk) begin
    if (!rst && cmp_en) begin
      chk("model_da_data", int'(da_data), pd[2]);
      chk("model_da_pulse", int'(da_pulse), int'(pp[2]));
      chk("model_cfg_ready", int'(cfg_ready), int'(!m_pend_full));
      chk("model_busy", int'(busy), int'(m_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  int smp[0:299];
  bit pls[0:299];

  task automatic send_cfg(input logic [W-1:0] fw, input logic [1:0] w,
                          input logic [7:0] a, input logic [7:0] o, output int waited);
    logic rdy;
    bit done;
    cfg_fword = fw; cfg_wave = w; cfg_amp = a; cfg_offs = o; cfg_valid = 1'b1;
    waited = 0; done = 0;
    while (!done && waited < 2000) begin
      rdy = cfg_ready;
      @(posedge da_clk);
      if (rdy) done = 1; else waited++;
      @(negedge da_clk);
    end
    cfg_valid = 1'b0;
    chk("cfg_accepted", int'(done), 1);
  endtask

  task automatic wait_pulse(input int budget);
    int k;
    k = 0;
    do begin @(negedge da_clk); k++; end while (!da_pulse && k < budget);
    chk("pulse_seen", int'(da_pulse), 1);
  endtask

  task automatic capture(input int n);
    smp[0] = da_data; pls[0] = da_pulse;
    for (int i = 1; i < n; i++) begin
      @(negedge da_clk);
      smp[i] = da_data; pls[i] = da_pulse;
    end
  endtask

  task automatic go_idle();
    int k;
    enable = 1'b0;
    k = 0;
    do begin @(negedge da_clk); k++; end while (busy && k < 5000);
    chk("go_idle", int'(busy), 0);
    repeat (4) @(negedge da_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, npl, mx, k;
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_fword = '0; cfg_wave = '0; cfg_amp = '0; cfg_offs = '0;
    repeat (3) @(negedge da_clk);
    chk("reset_da_data", int'(da_data), 0);
    chk("reset_da_pulse", int'(da_pulse), 0);
    chk("reset_cfg_ready", int'(cfg_ready), 1);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    cmp_en = 1;
    @(negedge da_clk);

    // saw ramp, full amplitude
    send_cfg(24'h010000, 2'd0, 8'd255, 8'd0, waited);
    enable = 1'b1;
    wait_pulse(600);
    capture(257);
    chk("t1_s0", smp[0], 0);
    chk("t1_s1", smp[1], 0);
    chk("t1_s2", smp[2], 1);
    chk("t1_s128", smp[128], 127);
    chk("t1_s255", smp[255], 254);
    chk("t1_pulse_period", int'(pls[256]), 1);
    npl = 0; mx = 0;
    for (int i = 1; i < 256; i++) begin
      if (pls[i]) npl++;
      if (smp[i] > mx) mx = smp[i];
    end
    chk("t1_no_inner_pulse", npl, 0);
    chk("t1_max", mx, 254);

    // square, amp 100, offset 50
    go_idle();
    send_cfg(24'h100000, 2'd2, 8'd100, 8'd50, waited);
    enable = 1'b1;
    wait_pulse(100);
    capture(33);
    chk("t2_s0", smp[0], 149);
    chk("t2_s7", smp[7], 149);
    chk("t2_s8", smp[8], 50);
    chk("t2_s15", smp[15], 50);
    chk("t2_s16", smp[16], 149);
    chk("t2_pulse16", int'(pls[16]), 1);
    npl = 0;
    for (int i = 1; i < 16; i++) if (pls[i]) npl++;
    chk("t2_no_inner_pulse", npl, 0);

    // saturation
    go_idle();
    send_cfg(24'h100000, 2'd2, 8'd255, 8'd200, waited);
    enable = 1'b1;
    wait_pulse(100);
    capture(17);
    chk("t3_high_sat", smp[0], 255);
    chk("t3_high_sat7", smp[7], 255);
    chk("t3_low", smp[8], 200);
    chk("t3_low15", smp[15], 200);

    // two back-to-back config changes while running
    send_cfg(24'h100000, 2'd2, 8'd50, 8'd200, waited);
    chk("t4_ready_low", int'(cfg_ready), 0);
    send_cfg(24'h100000, 2'd2, 8'd10, 8'd200, waited);
    chk("t4_second_stalled", int'(waited > 0), 1);
    wait_pulse(40);
    chk("t4_amp50_at_pulse", int'(da_data), 249);
    wait_pulse(40);
    chk("t4_amp10_at_pulse", int'(da_data), 209);

    // drop enable mid-period: period completes, then idle
    go_idle();
    send_cfg(24'h010000, 2'd0, 8'd255, 8'd30, waited);
    enable = 1'b1;
    wait_pulse(600);
    repeat (100) @(negedge da_clk);
    enable = 1'b0;
    k = 0;
    do begin @(negedge da_clk); k++; end while (busy && k < 400);
    chk("t5_cycles_to_idle", k, 153);
    repeat (3) @(negedge da_clk);
    chk("t5_idle_offs", int'(da_data), 30);

    // fword=0: STOP leaves at once
    send_cfg(24'h000000, 2'd0, 8'd255, 8'd30, waited);
    enable = 1'b1;
    repeat (5) @(negedge da_clk);
    enable = 1'b0;
    @(negedge da_clk);
    chk("t5b_stop_busy", int'(busy), 1);
    @(negedge da_clk);
    chk("t5b_idle_busy", int'(busy), 0);
    repeat (3) @(negedge da_clk);
    chk("t5b_idle_offs", int'(da_data), 30);

    // asynchronous reset mid-run with pending config held
    send_cfg(24'h010000, 2'd1, 8'd255, 8'd0, waited);
    enable = 1'b1;
    repeat (20) @(negedge da_clk);
    cfg_fword = 24'h020000; cfg_wave = 2'd0; cfg_amp = 8'd77; cfg_offs = 8'd5;
    cfg_valid = 1'b1;
    @(negedge da_clk);
    cfg_valid = 1'b0;
    chk("t6_pending_full", int'(cfg_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_da_data", int'(da_data), 0);
    chk("t6_rst_da_pulse", int'(da_pulse), 0);
    chk("t6_rst_cfg_ready", int'(cfg_ready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    enable = 1'b0;
    @(negedge da_clk);
    @(negedge da_clk);
    rst = 1'b0;
    @(negedge da_clk);
    send_cfg(24'h040000, 2'd1, 8'd200, 8'd20, waited);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        enable = ~enable;
      end else if (r < 8) begin
        send_cfg(W'($urandom_range(32'h020000, 32'h200000)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), waited);
      end
      @(negedge da_clk);
    end
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
